// File: rtl/mem_arb_module.sv
// ============================================================================
// mem_arb_module
// Round-robin arbiter and 4-beat burst sequencer between the I-side and D-side
// refill ports and the MMU memory controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 32
`endif
`ifndef BYTE_MASK_WIDTH
`define BYTE_MASK_WIDTH 16
`endif

module mem_arb_module #(
    parameter int BEAT_NUM  = 4,
    parameter int CTR_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req0_vld,
    input  logic [`PHY_ADDR_WIDTH-1:0]   i_req0_paddr,
    input  logic                         i_req1_vld,
    input  logic                         i_req1_wr,
    input  logic [`PHY_ADDR_WIDTH-1:0]   i_req1_paddr,
    input  logic [`BYTE_MASK_WIDTH-1:0]  i_req1_mask,
    input  logic [127:0]                 i_req1_wdat,
    output logic                         o_req0_gnt,
    output logic                         o_req1_gnt,
    output logic                         o_req1_wpop,
    output logic                         o_req0_rvld,
    output logic                         o_req1_rvld,
    output logic [127:0]                 o_rdat,
    output logic                         o_req0_done,
    output logic                         o_req1_done,
    output logic                         o_mem_ext_rden,
    output logic                         o_mem_ext_wren,
    output logic [`BYTE_MASK_WIDTH-1:0]  o_mem_ext_mask,
    output logic [2:0]                   o_mem_ext_burst,
    output logic [`PHY_ADDR_WIDTH-1:0]   o_mem_ext_paddr,
    output logic [127:0]                 o_mem_ext_wdat,
    output logic                         o_mem_ext_burst_start,
    output logic                         o_mem_ext_burst_end,
    output logic                         o_mem_ext_burst_vld,
    input  logic                         i_ext_mmu_rdy,
    input  logic                         i_ext_mmu_rd_ack,
    input  logic                         i_ext_mmu_wr_ack,
    input  logic [127:0]                 i_ext_mmu_rdat,
    output logic                         o_arb_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CTR_WIDTH-1:0] C_LAST_BEAT = CTR_WIDTH'(BEAT_NUM - 1);

    state_t                 r_state;
    logic [CTR_WIDTH-1:0]   r_cnt;
    logic                   r_last;
    logic                   r_port;
    logic                   r_wr;
    logic                   w_pick1;
    logic                   w_wr;

    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    assign w_pick1 = i_req1_vld & (~i_req0_vld | ~r_last);
    assign w_wr    = w_pick1 & i_req1_wr;

    // Write data passes straight through so the requester can advance on each pop.
    assign o_mem_ext_wdat = (o_mem_ext_burst_vld && r_wr) ? i_req1_wdat : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state               <= S_IDLE;
            r_cnt                 <= '0;
            r_last                <= 1'b1;
            r_port                <= 1'b0;
            r_wr                  <= 1'b0;
            o_req0_gnt            <= 1'b0;
            o_req1_gnt            <= 1'b0;
            o_req1_wpop           <= 1'b0;
            o_req0_rvld           <= 1'b0;
            o_req1_rvld           <= 1'b0;
            o_rdat                <= '0;
            o_req0_done           <= 1'b0;
            o_req1_done           <= 1'b0;
            o_mem_ext_rden        <= 1'b0;
            o_mem_ext_wren        <= 1'b0;
            o_mem_ext_mask        <= '0;
            o_mem_ext_burst       <= 3'd0;
            o_mem_ext_paddr       <= '0;
            o_mem_ext_burst_start <= 1'b0;
            o_mem_ext_burst_end   <= 1'b0;
            o_mem_ext_burst_vld   <= 1'b0;
            o_arb_err             <= 1'b0;
        end else begin
            o_req0_gnt      <= 1'b0;
            o_req1_gnt      <= 1'b0;
            o_req0_rvld     <= 1'b0;
            o_req1_rvld     <= 1'b0;
            o_req0_done     <= 1'b0;
            o_req1_done     <= 1'b0;
            o_mem_ext_burst <= 3'd4;

            if (i_ext_mmu_rd_ack && i_ext_mmu_wr_ack) begin
                o_arb_err <= 1'b1;
            end
            if ((i_ext_mmu_rd_ack || i_ext_mmu_wr_ack) &&
                (r_state == S_IDLE || r_state == S_BURST)) begin
                o_arb_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_ext_mmu_rdy && (i_req0_vld || i_req1_vld)) begin
                        r_state               <= S_BURST;
                        r_cnt                 <= '0;
                        r_last                <= w_pick1;
                        r_port                <= w_pick1;
                        r_wr                  <= w_wr;
                        o_mem_ext_paddr       <= w_pick1 ? i_req1_paddr : i_req0_paddr;
                        o_mem_ext_mask        <= w_pick1 ? i_req1_mask : '1;
                        o_req0_gnt            <= ~w_pick1;
                        o_req1_gnt            <= w_pick1;
                        o_mem_ext_burst_vld   <= 1'b1;
                        o_mem_ext_burst_start <= 1'b1;
                        o_mem_ext_burst_end   <= (C_LAST_BEAT == '0);
                        o_mem_ext_rden        <= ~w_wr;
                        o_mem_ext_wren        <= w_wr;
                        o_req1_wpop           <= w_wr;
                    end
                end
                S_BURST: begin
                    o_mem_ext_burst_start <= 1'b0;
                    o_mem_ext_rden        <= 1'b0;
                    o_mem_ext_wren        <= 1'b0;
                    if (r_cnt == C_LAST_BEAT) begin
                        r_state             <= S_WAIT;
                        r_cnt               <= '0;
                        o_mem_ext_burst_vld <= 1'b0;
                        o_mem_ext_burst_end <= 1'b0;
                        o_req1_wpop         <= 1'b0;
                    end else begin
                        r_cnt               <= r_cnt + 1'b1;
                        o_mem_ext_burst_end <= (r_cnt == C_LAST_BEAT - 1'b1);
                    end
                end
                S_WAIT: begin
                    // Acks of the wrong kind are flagged and otherwise ignored.
                    if (i_ext_mmu_rd_ack && !i_ext_mmu_wr_ack) begin
                        if (r_wr) begin
                            o_arb_err <= 1'b1;
                        end else begin
                            o_rdat      <= i_ext_mmu_rdat;
                            o_req0_rvld <= ~r_port;
                            o_req1_rvld <= r_port;
                            r_cnt       <= r_cnt + 1'b1;
                            if (r_cnt == C_LAST_BEAT) begin
                                r_state     <= S_DONE;
                                o_req0_done <= ~r_port;
                                o_req1_done <= r_port;
                            end
                        end
                    end else if (i_ext_mmu_wr_ack && !i_ext_mmu_rd_ack) begin
                        if (!r_wr) begin
                            o_arb_err <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            o_req0_done <= ~r_port;
                            o_req1_done <= r_port;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arb_module.sv
// ============================================================================
// tb_mem_arb_module
// Directed stimulus with a cycle-level reference model of the arbiter protocol.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 32
`endif
`ifndef BYTE_MASK_WIDTH
`define BYTE_MASK_WIDTH 16
`endif

module tb_mem_arb_module;

    localparam int AW   = `PHY_ADDR_WIDTH;
    localparam int MW   = `BYTE_MASK_WIDTH;
    localparam int BEAT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_req0_vld, i_req1_vld, i_req1_wr;
    logic [AW-1:0]   i_req0_paddr, i_req1_paddr;
    logic [MW-1:0]   i_req1_mask;
    wire  [127:0]    i_req1_wdat;
    logic            o_req0_gnt, o_req1_gnt, o_req1_wpop;
    logic            o_req0_rvld, o_req1_rvld, o_req0_done, o_req1_done;
    logic [127:0]    o_rdat, o_mem_ext_wdat;
    logic            o_mem_ext_rden, o_mem_ext_wren;
    logic [MW-1:0]   o_mem_ext_mask;
    logic [2:0]      o_mem_ext_burst;
    logic [AW-1:0]   o_mem_ext_paddr;
    logic            o_mem_ext_burst_start, o_mem_ext_burst_end, o_mem_ext_burst_vld;
    logic            i_ext_mmu_rdy, i_ext_mmu_rd_ack, i_ext_mmu_wr_ack;
    logic [127:0]    i_ext_mmu_rdat;
    logic            o_arb_err;

    always #5 clk = ~clk;

    mem_arb_module #(.BEAT_NUM(4), .CTR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_vld(i_req0_vld), .i_req0_paddr(i_req0_paddr),
        .i_req1_vld(i_req1_vld), .i_req1_wr(i_req1_wr), .i_req1_paddr(i_req1_paddr),
        .i_req1_mask(i_req1_mask), .i_req1_wdat(i_req1_wdat),
        .o_req0_gnt(o_req0_gnt), .o_req1_gnt(o_req1_gnt), .o_req1_wpop(o_req1_wpop),
        .o_req0_rvld(o_req0_rvld), .o_req1_rvld(o_req1_rvld), .o_rdat(o_rdat),
        .o_req0_done(o_req0_done), .o_req1_done(o_req1_done),
        .o_mem_ext_rden(o_mem_ext_rden), .o_mem_ext_wren(o_mem_ext_wren),
        .o_mem_ext_mask(o_mem_ext_mask), .o_mem_ext_burst(o_mem_ext_burst),
        .o_mem_ext_paddr(o_mem_ext_paddr), .o_mem_ext_wdat(o_mem_ext_wdat),
        .o_mem_ext_burst_start(o_mem_ext_burst_start), .o_mem_ext_burst_end(o_mem_ext_burst_end),
        .o_mem_ext_burst_vld(o_mem_ext_burst_vld),
        .i_ext_mmu_rdy(i_ext_mmu_rdy), .i_ext_mmu_rd_ack(i_ext_mmu_rd_ack),
        .i_ext_mmu_wr_ack(i_ext_mmu_wr_ack), .i_ext_mmu_rdat(i_ext_mmu_rdat),
        .o_arb_err(o_arb_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Port 1 requester: presents write beat widx, advances on each pop.
    logic [127:0] wbeats [4];
    logic [1:0]   widx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) widx <= 2'd0;
        else if (o_req1_wpop) widx <= widx + 2'd1;
    end
    assign i_req1_wdat = wbeats[widx];

    // Reference model: m_* hold what the DUT must show during the next cycle.
    bit            m_busy, m_fin, m_last, m_err, m_wr, m_port, emit;
    int            m_beat, m_acks;
    logic [AW-1:0] m_paddr;
    logic [MW-1:0] m_mask;
    logic [127:0]  m_rdat, e_wdat;
    logic [2:0]    m_burst;
    bit e_gnt0, e_gnt1, e_rvld0, e_rvld1, e_done0, e_done1;
    bit e_rden, e_wren, e_bvld, e_start, e_end, e_wpop;
    bit rd, wr, v0, v1, in_burst;
    logic [12:0] act_ctl, exp_ctl;

    always @(negedge clk) begin
        act_ctl = {o_req0_gnt, o_req1_gnt, o_req0_rvld, o_req1_rvld, o_req0_done, o_req1_done,
                   o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_burst_vld, o_mem_ext_burst_start,
                   o_mem_ext_burst_end, o_req1_wpop, o_arb_err};
        if (!rst_n) begin
            chk("mon_reset_ctl", act_ctl, '0);
            chk("mon_reset_addr", {o_mem_ext_burst, o_mem_ext_paddr, o_mem_ext_mask}, '0);
            chk("mon_reset_rdat", o_rdat, '0);
            chk("mon_reset_wdat", o_mem_ext_wdat, '0);
            m_busy = 0; m_fin = 0; m_last = 1; m_err = 0; m_wr = 0; m_port = 0;
            m_beat = 0; m_acks = 0; m_paddr = '0; m_mask = '0; m_rdat = '0; m_burst = 3'd0;
            {e_gnt0, e_gnt1, e_rvld0, e_rvld1, e_done0, e_done1} = '0;
            {e_rden, e_wren, e_bvld, e_start, e_end, e_wpop} = '0;
            e_wdat = '0;
        end else begin
            exp_ctl = {e_gnt0, e_gnt1, e_rvld0, e_rvld1, e_done0, e_done1,
                       e_rden, e_wren, e_bvld, e_start, e_end, e_wpop, m_err};
            chk("mon_ctl", act_ctl, exp_ctl);
            chk("mon_paddr", o_mem_ext_paddr, m_paddr);
            chk("mon_mask", o_mem_ext_mask, m_mask);
            chk("mon_burst_code", o_mem_ext_burst, m_burst);
            chk("mon_rdat", o_rdat, m_rdat);
            chk("mon_wdat", o_mem_ext_wdat, e_wdat);
            chk("mon_excl_gd", $onehot0({o_req0_gnt, o_req1_gnt, o_req0_done, o_req1_done}), 1);
            chk("mon_excl_rvld", $onehot0({o_req0_rvld, o_req1_rvld}), 1);

            rd = i_ext_mmu_rd_ack; wr = i_ext_mmu_wr_ack;
            v0 = i_req0_vld;       v1 = i_req1_vld;
            in_burst = m_busy && (m_beat < BEAT);
            {e_gnt0, e_gnt1, e_rvld0, e_rvld1, e_done0, e_done1} = '0;
            {e_rden, e_wren, e_bvld, e_start, e_end, e_wpop} = '0;
            e_wdat = '0;
            emit = 0;
            m_burst = 3'd4;
            if (rd && wr) m_err = 1;
            if ((rd || wr) && (!m_busy || in_burst)) m_err = 1;
            if (m_fin) begin
                m_fin = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (i_ext_mmu_rdy && (v0 || v1)) begin
                    m_port  = (v0 && v1) ? ~m_last : v1;
                    m_last  = m_port;
                    m_wr    = m_port && i_req1_wr;
                    m_paddr = m_port ? i_req1_paddr : i_req0_paddr;
                    m_mask  = m_port ? i_req1_mask : {MW{1'b1}};
                    m_busy  = 1; m_beat = 0; m_acks = 0;
                    if (m_port) e_gnt1 = 1; else e_gnt0 = 1;
                    emit = 1;
                end
            end else if (m_beat < BEAT - 1) begin
                m_beat++;
                emit = 1;
            end else if (m_beat == BEAT - 1) begin
                m_beat = BEAT;
            end else if (rd && !wr) begin
                if (m_wr) m_err = 1;
                else begin
                    m_rdat = i_ext_mmu_rdat;
                    if (m_port) e_rvld1 = 1; else e_rvld0 = 1;
                    m_acks++;
                    if (m_acks == BEAT) begin
                        if (m_port) e_done1 = 1; else e_done0 = 1;
                        m_fin = 1;
                    end
                end
            end else if (wr && !rd) begin
                if (!m_wr) m_err = 1;
                else begin
                    if (m_port) e_done1 = 1; else e_done0 = 1;
                    m_fin = 1;
                end
            end
            if (emit) begin
                e_bvld  = 1;
                e_start = (m_beat == 0);
                e_end   = (m_beat == BEAT - 1);
                e_rden  = (m_beat == 0) && !m_wr;
                e_wren  = (m_beat == 0) && m_wr;
                e_wpop  = m_wr;
                e_wdat  = m_wr ? wbeats[m_beat] : '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(output int port);
        port = -1;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (o_req0_gnt) begin port = 0; break; end
            if (o_req1_gnt) begin port = 1; break; end
        end
        if (port < 0) timeout("wait_gnt");
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!o_mem_ext_burst_end && n < 30) begin
            tick();
            n++;
        end
        if (!o_mem_ext_burst_end) timeout("wait_burst_end");
    endtask

    // Returns BEAT read beats back-to-back; finishes one cycle after the done pulse.
    task automatic read_acks(input int port, input logic [127:0] base);
        for (int k = 0; k < BEAT; k++) begin
            i_ext_mmu_rd_ack = 1'b1;
            i_ext_mmu_rdat   = base + 128'(k);
            tick();
            chk("rd_rvld", (port == 0) ? o_req0_rvld : o_req1_rvld, 1);
            chk("rd_rdat", o_rdat, base + 128'(k));
        end
        i_ext_mmu_rd_ack = 1'b0;
        chk("rd_done", (port == 0) ? o_req0_done : o_req1_done, 1);
        tick();
    endtask

    task automatic complete_read(input int port, input logic [127:0] base);
        wait_end();
        tick();
        read_acks(port, base);
    endtask

    int  gp;
    int  order [3];
    bit  seen;
    logic [127:0] a_base;

    initial begin
        i_req0_vld = 0; i_req1_vld = 0; i_req1_wr = 0;
        i_req0_paddr = '0; i_req1_paddr = '0; i_req1_mask = '0;
        i_ext_mmu_rdy = 1; i_ext_mmu_rd_ack = 0; i_ext_mmu_wr_ack = 0; i_ext_mmu_rdat = '0;
        wbeats[0] = 128'h0000_1111_2222_3333_4444_5555_6666_7770;
        wbeats[1] = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFF1;
        wbeats[2] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3212;
        wbeats[3] = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF3;
        a_base    = 128'hA5A5_0000_0000_0000_0000_0000_0000_A000;

        repeat (2) tick();
        chk("reset_err", o_arb_err, 0);
        chk("reset_burst_code", o_mem_ext_burst, 0);
        rst_n = 1'b1;
        tick();

        // Port 0 read at 0x1000
        i_req0_paddr = 32'h1000;
        i_req0_vld   = 1'b1;
        tick();
        chk("t1_gnt0", o_req0_gnt, 1);
        chk("t1_beat0", {o_mem_ext_burst_vld, o_mem_ext_burst_start, o_mem_ext_burst_end,
                         o_mem_ext_rden, o_mem_ext_wren}, 5'b11010);
        chk("t1_paddr", o_mem_ext_paddr, 32'h1000);
        i_req0_vld = 1'b0;
        tick();
        chk("t1_beat1", {o_mem_ext_burst_vld, o_mem_ext_burst_start, o_mem_ext_rden}, 3'b100);
        repeat (2) tick();
        chk("t1_beat3_end", {o_mem_ext_burst_vld, o_mem_ext_burst_end}, 2'b11);
        tick();
        chk("t1_wait_idle_bus", o_mem_ext_burst_vld, 0);
        read_acks(0, a_base);
        chk("t1_last_rdat", o_rdat, a_base + 128'd3);

        // Port 1 write at 0x2000
        i_req1_paddr = 32'h2000;
        i_req1_mask  = {MW{1'b1}};
        i_req1_wr    = 1'b1;
        i_req1_vld   = 1'b1;
        tick();
        chk("t2_gnt1", o_req1_gnt, 1);
        chk("t2_wren_beat0", {o_mem_ext_wren, o_mem_ext_rden, o_req1_wpop}, 3'b101);
        chk("t2_wdat0", o_mem_ext_wdat, wbeats[0]);
        i_req1_vld = 1'b0;
        for (int b = 1; b < BEAT; b++) begin
            tick();
            chk("t2_wdat", o_mem_ext_wdat, wbeats[b]);
            chk("t2_wpop", o_req1_wpop, 1);
        end
        repeat (2) tick();
        i_ext_mmu_wr_ack = 1'b1;
        tick();
        i_ext_mmu_wr_ack = 1'b0;
        chk("t2_done1", {o_req1_done, o_req1_rvld, o_req0_rvld}, 3'b100);
        tick();
        i_req1_wr = 1'b0;

        // Round-robin with both ports requesting from reset
        do_reset();
        i_req0_paddr = 32'h3000;
        i_req1_paddr = 32'h4000;
        i_req1_mask  = 16'h00F0;
        i_req0_vld   = 1'b1;
        i_req1_vld   = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_gnt(gp);
            order[t] = gp;
            if (t == 2) begin
                i_req0_vld = 1'b0;
                i_req1_vld = 1'b0;
            end
            complete_read((gp < 0) ? 0 : gp, a_base + 128'h100 * 128'(t + 1));
        end
        chk("t3_order0", 32'(order[0]), 0);
        chk("t3_order1", 32'(order[1]), 1);
        chk("t3_order2", 32'(order[2]), 0);

        // Controller busy holds off the grant
        i_ext_mmu_rdy = 1'b0;
        i_req0_paddr  = 32'h5000;
        i_req0_vld    = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (o_req0_gnt || o_req1_gnt) seen = 1;
        end
        chk("t4_no_gnt_rdy_low", seen, 0);
        i_ext_mmu_rdy = 1'b1;
        tick();
        chk("t4_gnt_after_rdy", o_req0_gnt, 1);
        i_req0_vld = 1'b0;
        complete_read(0, a_base + 128'h500);

        // Protocol errors are sticky; the read still completes
        chk("t5_err_clear", o_arb_err, 0);
        i_ext_mmu_rd_ack = 1'b1;
        tick();
        i_ext_mmu_rd_ack = 1'b0;
        chk("t5_err_idle_rdack", o_arb_err, 1);
        i_req0_paddr = 32'h6000;
        i_req0_vld   = 1'b1;
        wait_gnt(gp);
        i_req0_vld = 1'b0;
        wait_end();
        tick();
        i_ext_mmu_wr_ack = 1'b1;
        tick();
        i_ext_mmu_wr_ack = 1'b0;
        chk("t5_err_wrack_in_read", o_arb_err, 1);
        chk("t5_no_done_on_bad_ack", {o_req0_done, o_req1_done}, 2'b00);
        read_acks(0, a_base + 128'h600);
        chk("t5_err_sticky", o_arb_err, 1);

        // Reset during beat 2 of a burst
        i_req0_paddr = 32'h7000;
        i_req0_vld   = 1'b1;
        wait_gnt(gp);
        i_req0_vld = 1'b0;
        repeat (2) tick();
        chk("t6_beat2", {o_mem_ext_burst_vld, o_mem_ext_burst_start, o_mem_ext_burst_end}, 3'b100);
        rst_n = 1'b0;
        #1;
        chk("t6_async_ctl", {o_req0_gnt, o_req1_gnt, o_req0_done, o_req1_done, o_mem_ext_burst_vld,
                             o_mem_ext_burst_start, o_mem_ext_rden, o_arb_err}, 8'h00);
        chk("t6_async_data", {o_mem_ext_paddr, o_mem_ext_burst}, '0);
        chk("t6_async_rdat", o_rdat, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t6_err_cleared", o_arb_err, 0);
        i_req0_paddr = 32'h8000;
        i_req0_vld   = 1'b1;
        tick();
        chk("t6_gnt_after_reset", o_req0_gnt, 1);
        chk("t6_paddr", o_mem_ext_paddr, 32'h8000);
        i_req0_vld = 1'b0;
        complete_read(0, a_base + 128'h800);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
